// File: rtl/chip_bus_pkg.sv
// Shared constants for the chip bus command scheduler.
// State encoding, target selectors and read flag.
package chip_bus_pkg;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_I2C_REQ    = 3'd1;
    localparam logic [2:0] S_I2C_WAIT   = 3'd2;
    localparam logic [2:0] S_SPI_SETUP  = 3'd3;
    localparam logic [2:0] S_SPI_ACCESS = 3'd4;
    localparam logic [2:0] S_SPI_WAIT   = 3'd5;
    localparam logic [2:0] S_RESP       = 3'd6;

    localparam logic TGT_I2C = 1'b0;
    localparam logic TGT_SPI = 1'b1;
    localparam logic RD      = 1'b1;

endpackage

// File: rtl/sched_timeout_cnt.sv
// Wait-state watchdog for the command scheduler.
// Counts enabled cycles; expired flags the last allowed one.
module sched_timeout_cnt
#(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    assign expired = enable && (cnt == LAST);

    // Count wait cycles, saturating at the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/chip_bus_sched.sv
// Serialises host commands onto the I2C or APB-SPI master.
// One command in flight; one response per command.
module chip_bus_sched
    import chip_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_tgt,
    input  logic        cmd_rd,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [6:0]  cfg_slave_addr,
    input  logic        cfg_i2aen,
    input  logic [1:0]  cfg_i2ac,
    input  logic [1:0]  cfg_i2dc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic [6:0]  i2c_slave_addr,
    output logic        i2c_master_rw,
    output logic [31:0] i2c_master_addr,
    output logic [31:0] i2c_master_din,
    output logic        i2c_master_valid,
    output logic        i2aen,
    output logic [1:0]  i2ac,
    output logic [1:0]  i2dc,
    input  logic        i2c_master_busy,
    input  logic        i2c_rd_valid,
    input  logic [31:0] i2c_rd_data,
    output logic        spim_psel,
    output logic        spim_penable,
    output logic        spim_pwrite,
    output logic [7:0]  spim_paddr,
    output logic [7:0]  spim_pwdata,
    input  logic [7:0]  spim_prdata,
    input  logic        spim_busy,
    output logic        sched_busy
);

    logic [2:0]  state;
    logic        rd_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [6:0]  slave_q;
    logic        aen_q;
    logic [1:0]  ac_q;
    logic [1:0]  dc_q;
    logic        seen_busy;
    logic        rd_got;
    logic        spi_first;
    logic [31:0] rdata_q;
    logic        timeout_q;

    logic accept;
    logic i2c_done;
    logic spi_done;
    logic to_en;
    logic to_expired;

    assign cmd_ready = (state == S_IDLE) && !RESET;
    assign accept    = cmd_valid && cmd_ready;

    // Busy must have been seen to fall; a read also needs its data,
    // which may arrive in the very cycle busy drops.
    assign i2c_done = seen_busy && !i2c_master_busy &&
                      ((rd_q != RD) || rd_got || i2c_rd_valid);
    assign spi_done = !spi_first && !spim_busy;

    assign to_en = (state == S_I2C_WAIT) || (state == S_SPI_WAIT);

    sched_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_to (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (!to_en),
        .enable  (to_en),
        .expired (to_expired)
    );

    assign i2c_slave_addr   = slave_q;
    assign i2c_master_rw    = rd_q;
    assign i2c_master_addr  = addr_q;
    assign i2c_master_din   = wdata_q;
    assign i2c_master_valid = (state == S_I2C_REQ);
    assign i2aen            = aen_q;
    assign i2ac             = ac_q;
    assign i2dc             = dc_q;

    assign spim_psel    = (state == S_SPI_SETUP) || (state == S_SPI_ACCESS);
    assign spim_penable = (state == S_SPI_ACCESS);
    assign spim_pwrite  = spim_psel && (rd_q != RD);
    assign spim_paddr   = addr_q[7:0];
    assign spim_pwdata  = wdata_q[7:0];

    assign rsp_valid   = (state == S_RESP);
    assign rsp_data    = rsp_valid ? rdata_q : '0;
    assign rsp_timeout = rsp_valid && timeout_q;
    assign sched_busy  = (state != S_IDLE);

    // Hold the accepted command and config stable until the next accept.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            slave_q <= '0;
            aen_q   <= 1'b0;
            ac_q    <= '0;
            dc_q    <= '0;
        end else if (accept) begin
            rd_q    <= cmd_rd;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            slave_q <= cfg_slave_addr;
            aen_q   <= cfg_i2aen;
            ac_q    <= cfg_i2ac;
            dc_q    <= cfg_i2dc;
        end
    end

    // Sequence one command through its target and into the response slot.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            seen_busy <= 1'b0;
            rd_got    <= 1'b0;
            spi_first <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        rdata_q   <= '0;
                        timeout_q <= 1'b0;
                        state     <= (cmd_tgt == TGT_I2C) ?
                                     S_I2C_REQ : S_SPI_SETUP;
                    end
                end
                S_I2C_REQ: begin
                    seen_busy <= 1'b0;
                    rd_got    <= 1'b0;
                    state     <= S_I2C_WAIT;
                end
                S_I2C_WAIT: begin
                    if (i2c_master_busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (i2c_rd_valid && (rd_q == RD)) begin
                        rdata_q <= i2c_rd_data;
                        rd_got  <= 1'b1;
                    end
                    if (i2c_done) begin
                        state <= S_RESP;
                    end else if (to_expired) begin
                        rdata_q   <= '0;
                        timeout_q <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_SPI_SETUP: begin
                    state <= S_SPI_ACCESS;
                end
                S_SPI_ACCESS: begin
                    if (rd_q == RD) begin
                        rdata_q <= {24'd0, spim_prdata};
                    end
                    spi_first <= 1'b1;
                    state     <= S_SPI_WAIT;
                end
                S_SPI_WAIT: begin
                    spi_first <= 1'b0;
                    if (spi_done) begin
                        state <= S_RESP;
                    end else if (to_expired) begin
                        rdata_q   <= '0;
                        timeout_q <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
